// File: rtl/arc_microsequencer_pkg.sv
// rtl/arc_microsequencer_pkg.sv - shared codes, state enum and flag types for the ARC sequencer
package arc_microsequencer_pkg;

    // Register-file codes presented on the A/B/C control buses
    localparam logic [5:0] REG_R0 = 6'd1;
    localparam logic [5:0] REG_R1 = 6'd2;
    localparam logic [5:0] REG_R2 = 6'd3;
    localparam logic [5:0] REG_R3 = 6'd4;
    localparam logic [5:0] REG_RS = 6'd5;
    localparam logic [5:0] REG_PC = 6'd6;
    localparam logic [5:0] REG_IR = 6'd7;
    localparam logic [5:0] REG_T0 = 6'd8;
    localparam logic [5:0] NOLOAD = 6'd15;

    // Clear-decoder selection that clears nothing
    localparam logic [3:0] CLR_NONE = 4'd15;

    // ALU operations the sequencer itself requests; codes sit above the op3 range used by EXEC
    localparam logic [3:0] ALU_PASSA  = 4'd12;
    localparam logic [3:0] ALU_INC4   = 4'd13;
    localparam logic [3:0] ALU_BRDISP = 4'd14;

    // Branch condition field IR[28:25]
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;

    // Instruction format fields
    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [2:0] OP2_BICC = 3'b010;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_PC_INC,
        ST_DECODE,
        ST_EXEC_ALU,
        ST_BRANCH,
        ST_HALT,
        ST_FAULT
    } stateT;

    // Latched condition codes, active-high
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } psrT;

endpackage

// File: rtl/arc_microsequencer_branch_eval.sv
// rtl/arc_microsequencer_branch_eval.sv - branch condition evaluator (cond x PSR -> taken)
module arc_branch_eval
    import arc_microsequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  psrT        psr,
    output logic       taken
);

    // Unlisted condition codes are never taken
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BA:   taken = 1'b1;
            COND_BE:   taken = psr.z;
            COND_BCS:  taken = psr.c;
            COND_BNEG: taken = psr.n;
            COND_BVS:  taken = psr.v;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/arc_microsequencer.sv
// rtl/arc_microsequencer.sv - hardwired fetch/increment/decode/execute control unit
module arc_microsequencer
    import arc_microsequencer_pkg::*;
#(
    parameter int DATAWIDTH_BUS               = 32,
    parameter int DATAWIDTH_ALU_SELECTION     = 4,
    parameter int DATA_BUS_CONTROL            = 6,
    parameter int DATAWIDTH_DECODER_SELECTION = 4,
    parameter int MEM_TIMEOUT                 = 255
) (
    input  logic                                   uSEQ_CLOCK_50,
    input  logic                                   uSEQ_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]               uSEQ_Registro_IR,
    input  logic                                   uSEQ_Habilitador_PSR,
    input  logic                                   uSEQ_overflow_InLow,
    input  logic                                   uSEQ_carry_InLow,
    input  logic                                   uSEQ_negative_InLow,
    input  logic                                   uSEQ_zero_InLow,
    input  logic                                   uSEQ_mem_ack,
    output logic                                   uSEQ_mem_req,
    output logic [DATA_BUS_CONTROL-1:0]            uSEQ_BUS_CONTROL_A,
    output logic [DATA_BUS_CONTROL-1:0]            uSEQ_BUS_CONTROL_B,
    output logic [DATA_BUS_CONTROL-1:0]            uSEQ_BUS_CONTROL_C,
    output logic                                   uSEQ_BUS_SELECTOR_A,
    output logic                                   uSEQ_BUS_SELECTOR_B,
    output logic                                   uSEQ_BUS_SELECTOR_C,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     uSEQ_aluselection_OutBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] uSEQ_decoderclearselection_OutBUS,
    output logic [3:0]                             uSEQ_psr_OutBUS,
    output logic                                   uSEQ_halted,
    output logic                                   uSEQ_fault
);

    // The last wait cycle is the one where the counter is about to reach MEM_TIMEOUT
    localparam logic [7:0] TIMEOUT_MAX  = 8'(MEM_TIMEOUT);
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    stateT      state;
    stateT      nextState;
    logic [7:0] waitCount;
    psrT        psrReg;
    logic       branchTaken;

    logic [1:0] irOp;
    logic [2:0] irOp2;

    assign irOp  = uSEQ_Registro_IR[31:30];
    assign irOp2 = uSEQ_Registro_IR[24:22];

    arc_branch_eval branchEval (
        .cond  (uSEQ_Registro_IR[28:25]),
        .psr   (psrReg),
        .taken (branchTaken)
    );

    // State register
    always_ff @(posedge uSEQ_CLOCK_50 or negedge uSEQ_RESET_InLow) begin
        if (!uSEQ_RESET_InLow) begin
            state <= ST_FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Fetch wait counter: zero outside FETCH so every fetch starts fresh, saturating inside it
    always_ff @(posedge uSEQ_CLOCK_50 or negedge uSEQ_RESET_InLow) begin
        if (!uSEQ_RESET_InLow) begin
            waitCount <= 8'd0;
        end else if (state != ST_FETCH) begin
            waitCount <= 8'd0;
        end else if (!uSEQ_mem_ack && (waitCount != TIMEOUT_MAX)) begin
            waitCount <= waitCount + 8'd1;
        end
    end

    // Condition codes only move at the end of a CC-setting EXEC cycle
    always_ff @(posedge uSEQ_CLOCK_50 or negedge uSEQ_RESET_InLow) begin
        if (!uSEQ_RESET_InLow) begin
            psrReg <= '0;
        end else if ((state == ST_EXEC_ALU) && uSEQ_Habilitador_PSR) begin
            psrReg <= '{n: ~uSEQ_negative_InLow, z: ~uSEQ_zero_InLow,
                        v: ~uSEQ_overflow_InLow, c: ~uSEQ_carry_InLow};
        end
    end

    // Next-state decode; an ack on the timeout cycle still completes the fetch
    always_comb begin
        nextState = state;
        case (state)
            ST_FETCH: begin
                if (uSEQ_mem_ack) begin
                    nextState = ST_PC_INC;
                end else if (waitCount >= TIMEOUT_LAST) begin
                    nextState = ST_FAULT;
                end
            end
            ST_PC_INC: nextState = ST_DECODE;
            ST_DECODE: begin
                if (uSEQ_Registro_IR == '0) begin
                    nextState = ST_HALT;
                end else if (irOp == OP_ARITH) begin
                    nextState = ST_EXEC_ALU;
                end else if ((irOp == OP_FMT2) && (irOp2 == OP2_BICC)) begin
                    nextState = ST_BRANCH;
                end else begin
                    nextState = ST_FETCH;
                end
            end
            ST_EXEC_ALU: nextState = ST_FETCH;
            ST_BRANCH:   nextState = ST_FETCH;
            ST_HALT:     nextState = ST_HALT;
            ST_FAULT:    nextState = ST_FAULT;
            default:     nextState = ST_FETCH;
        endcase
    end

    // Moore outputs; request and IR load are held off while reset is low since state already reads FETCH
    always_comb begin
        uSEQ_mem_req             = 1'b0;
        uSEQ_BUS_CONTROL_A       = DATA_BUS_CONTROL'(REG_PC);
        uSEQ_BUS_CONTROL_B       = DATA_BUS_CONTROL'(REG_PC);
        uSEQ_BUS_CONTROL_C       = DATA_BUS_CONTROL'(NOLOAD);
        uSEQ_BUS_SELECTOR_A      = 1'b0;
        uSEQ_BUS_SELECTOR_B      = 1'b0;
        uSEQ_BUS_SELECTOR_C      = 1'b0;
        uSEQ_aluselection_OutBUS = DATAWIDTH_ALU_SELECTION'(ALU_PASSA);
        uSEQ_halted              = 1'b0;
        uSEQ_fault               = 1'b0;
        case (state)
            ST_FETCH: begin
                uSEQ_mem_req       = 1'b1;
                uSEQ_BUS_CONTROL_C = DATA_BUS_CONTROL'(REG_IR);
            end
            ST_PC_INC: begin
                uSEQ_aluselection_OutBUS = DATAWIDTH_ALU_SELECTION'(ALU_INC4);
                uSEQ_BUS_CONTROL_C       = DATA_BUS_CONTROL'(REG_PC);
            end
            ST_EXEC_ALU: begin
                uSEQ_BUS_SELECTOR_A      = 1'b1;
                uSEQ_BUS_SELECTOR_B      = 1'b1;
                uSEQ_BUS_SELECTOR_C      = 1'b1;
                uSEQ_aluselection_OutBUS = DATAWIDTH_ALU_SELECTION'(uSEQ_Registro_IR[22:19]);
            end
            ST_BRANCH: begin
                if (branchTaken) begin
                    uSEQ_aluselection_OutBUS = DATAWIDTH_ALU_SELECTION'(ALU_BRDISP);
                    uSEQ_BUS_CONTROL_C       = DATA_BUS_CONTROL'(REG_PC);
                end
            end
            ST_HALT:  uSEQ_halted = 1'b1;
            ST_FAULT: uSEQ_fault  = 1'b1;
            default: ;
        endcase
        if (!uSEQ_RESET_InLow) begin
            uSEQ_mem_req       = 1'b0;
            uSEQ_BUS_CONTROL_C = DATA_BUS_CONTROL'(NOLOAD);
        end
    end

    assign uSEQ_decoderclearselection_OutBUS = DATAWIDTH_DECODER_SELECTION'(CLR_NONE);
    assign uSEQ_psr_OutBUS                   = psrReg;

endmodule
